// File: rtl/fsm_bus_arb.sv
// fsm_bus_arb
//   Round-robin arbiter and timing sequencer for the shared FLASH/SRAM bus.
//   NCLIENT masters issue single-word read or write requests. The block picks
//   one requester, drives the shared address and data pins, and times the
//   strobes: SETUP, then the strobe phase (ACCESS), then HOLD, then TURN idle
//   cycles. It returns a one-cycle ack, and for reads the captured data.
//
//   Optional feature macro: FSM_BUS_RDY_EN. When it is defined, the strobe
//   phase stretches while rdy_i is low, up to RDY_TIMEOUT extra cycles. A
//   timeout acks with an err_o pulse. When it is not defined, rdy_i is
//   ignored and err_o is always 0.
//
// Ports
//   p125clk, p125rst      clock, synchronous active-high reset
//   req_i/we_i            per-client request (held until ack) and 1=write
//   addr_i/wdata_i        packed per-client address / write data
//   ack_o, rdata_o        completion pulse to winner, read data (held)
//   fsm_a_o               address pins
//   fsm_d_o, fsm_d_oe     data out pins and tristate enable
//   fsm_d_i               data in pins
//   ce_n_o, oe_n_o, we_n_o  chip enables and strobes, active low
//   rdy_i, err_o          device ready, per-client timeout pulse
module fsm_bus_arb #(
  parameter int NCLIENT     = 2,
  parameter int AW          = 26,
  parameter int DW          = 32,
  parameter int RD_WAIT     = 8,
  parameter int WR_WAIT     = 6,
  parameter int TURN        = 1,
  parameter int RDY_TIMEOUT = 255
) (
  input  logic                  p125clk,
  input  logic                  p125rst,
  input  logic [NCLIENT-1:0]    req_i,
  input  logic [NCLIENT-1:0]    we_i,
  input  logic [NCLIENT*AW-1:0] addr_i,
  input  logic [NCLIENT*DW-1:0] wdata_i,
  output logic [NCLIENT-1:0]    ack_o,
  output logic [DW-1:0]         rdata_o,
  output logic [AW-1:0]         fsm_a_o,
  output logic [DW-1:0]         fsm_d_o,
  output logic                  fsm_d_oe,
  input  logic [DW-1:0]         fsm_d_i,
  output logic [NCLIENT-1:0]    ce_n_o,
  output logic                  oe_n_o,
  output logic                  we_n_o,
  input  logic                  rdy_i,
  output logic [NCLIENT-1:0]    err_o
);

  localparam int PW  = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam int M1  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
`ifdef FSM_BUS_RDY_EN
  localparam int M2  = (M1 > RDY_TIMEOUT) ? M1 : RDY_TIMEOUT;
`else
  localparam int M2  = M1;
`endif
  // TURN also reuses the down-counter, so the counter must be wide enough for it.
  localparam int M3  = (M2 > TURN) ? M2 : TURN;
  localparam int CW  = $clog2(M3 + 1);

  localparam logic [CW-1:0] RD_LD   = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LD   = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] TURN_LD = CW'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_TURN
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [AW-1:0]       fsm_a_q, fsm_a_d;
  logic [DW-1:0]       fsm_d_q, fsm_d_d;
  logic                d_oe_q, d_oe_d;
  logic [NCLIENT-1:0]  ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [NCLIENT-1:0]  ack_q, ack_d;
  logic [NCLIENT-1:0]  err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;
`ifdef FSM_BUS_RDY_EN
  logic [CW-1:0]       ext_q, ext_d;
  localparam logic [CW-1:0] EXT_LIM = CW'(RDY_TIMEOUT);
`else
  logic unused_rdy;
  assign unused_rdy = rdy_i;
`endif

  // Unpack the per-client buses into arrays. This lets the winner index select directly.
  logic [AW-1:0] addr_arr  [NCLIENT];
  logic [DW-1:0] wdata_arr [NCLIENT];
  for (genvar k = 0; k < NCLIENT; k++) begin : g_unpack
    assign addr_arr[k]  = addr_i[k*AW +: AW];
    assign wdata_arr[k] = wdata_i[k*DW +: DW];
  end

  // Round-robin search. Start at ptr+1, wrap, and stop at the first requester.
  // The last winner is searched last, so every requester is served within
  // NCLIENT grants.
  logic [PW-1:0] win;
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NCLIENT; i++) begin
      idx = (int'(ptr_q) + i) % NCLIENT;
      if (!found && req_i[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  logic acc_end, acc_tmo;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    fsm_a_d = fsm_a_q;
    fsm_d_d = fsm_d_q;
    d_oe_d  = d_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    acc_end = 1'b0;
    acc_tmo = 1'b0;
`ifdef FSM_BUS_RDY_EN
    ext_d   = ext_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          ptr_d       = win;
          wr_d        = we_i[win];
          fsm_a_d     = addr_arr[win];
          fsm_d_d     = wdata_arr[win];
          ce_n_d      = '1;
          ce_n_d[win] = 1'b0;
          d_oe_d      = we_i[win];
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = wr_q ? WR_LD : RD_LD;
        oe_n_d  = wr_q;
        we_n_d  = ~wr_q;
        state_d = S_ACCESS;
`ifdef FSM_BUS_RDY_EN
        ext_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
`ifdef FSM_BUS_RDY_EN
        // Base strobe time is complete. Keep the strobe asserted while the
        // device holds rdy low, up to the extension limit.
        else if (!rdy_i) begin
          if (ext_q == EXT_LIM) acc_tmo = 1'b1;
          else                  ext_d   = ext_q + 1'b1;
        end
`endif
        else begin
          acc_end = 1'b1;
        end
      end
      S_HOLD: begin
        ce_n_d = '1;
        d_oe_d = 1'b0;
        if (TURN > 0) begin
          cnt_d   = TURN_LD;
          state_d = S_TURN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Leave ACCESS. Strobes go high and the ack is issued for the HOLD cycle.
    // A timed-out read leaves rdata unchanged.
    if (acc_end || acc_tmo) begin
      oe_n_d         = 1'b1;
      we_n_d         = 1'b1;
      ack_d[ptr_q]   = 1'b1;
      err_d[ptr_q]   = acc_tmo;
      state_d        = S_HOLD;
      if (acc_end && !wr_q) rdata_d = fsm_d_i;
    end
  end

  always_ff @(posedge p125clk) begin
    if (p125rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NCLIENT - 1);
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      fsm_a_q <= '0;
      fsm_d_q <= '0;
      d_oe_q  <= 1'b0;
      ce_n_q  <= '1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
`ifdef FSM_BUS_RDY_EN
      ext_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      fsm_a_q <= fsm_a_d;
      fsm_d_q <= fsm_d_d;
      d_oe_q  <= d_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef FSM_BUS_RDY_EN
      ext_q   <= ext_d;
`endif
    end
  end

  assign ack_o    = ack_q;
  assign rdata_o  = rdata_q;
  assign fsm_a_o  = fsm_a_q;
  assign fsm_d_o  = fsm_d_q;
  assign fsm_d_oe = d_oe_q;
  assign ce_n_o   = ce_n_q;
  assign oe_n_o   = oe_n_q;
  assign we_n_o   = we_n_q;
`ifdef FSM_BUS_RDY_EN
  assign err_o    = err_q;
`else
  logic unused_err;
  assign unused_err = |err_q;
  assign err_o      = '0;
`endif

endmodule

// File: tb/tb_fsm_bus_arb.sv
// Directed bench for fsm_bus_arb with its default timing (RD_WAIT=8,
// WR_WAIT=6, TURN=1). It covers reset, a read, a write, round-robin
// alternation and reset in the middle of a transaction. The rdy
// extension and timeout steps run when FSM_BUS_RDY_EN is defined.
// Cycle n means the interval after the n-th clock edge that follows the
// cycle in which the request is first seen in IDLE.
module tb_fsm_bus_arb;
  localparam int NC = 2, AW = 26, DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC-1:0]  req, we, ack, ce_n, err;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [DW-1:0]  rdata, d_o, d_i;
  logic [AW-1:0]  a_o;
  logic           d_oe, oe_n, we_n, rdy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsm_bus_arb #(.NCLIENT(NC), .AW(AW), .DW(DW), .RD_WAIT(8), .WR_WAIT(6),
                .TURN(1), .RDY_TIMEOUT(4)) dut (
    .p125clk(clk), .p125rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .fsm_a_o(a_o),
    .fsm_d_o(d_o), .fsm_d_oe(d_oe), .fsm_d_i(d_i), .ce_n_o(ce_n),
    .oe_n_o(oe_n), .we_n_o(we_n), .rdy_i(rdy), .err_o(err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; d_i = '0; rdy = 1'b1;
    tick(); tick(); tick();
    chk("rst_ce_n", ce_n, 2'b11);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_a", a_o, 0);
    chk("rst_d_o", d_o, 0);

    // Read, client 0. The ack comes in cycle 10.
    rst = 1'b0;
    addr[0 +: AW] = 26'h0000123;
    addr[AW +: AW] = 26'h3000456;
    d_i = 32'hDEADBEEF;
    req = 2'b01; we = 2'b00;
    tick();
    chk("rd_setup_ce", ce_n, 2'b10);
    chk("rd_setup_a", a_o, 26'h0000123);
    chk("rd_setup_oe", oe_n, 1);
    chk("rd_setup_doe", d_oe, 0);
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("rd_acc_oe", oe_n, 0);
      chk("rd_acc_ack", ack, 0);
      chk("rd_acc_doe", d_oe, 0);
    end
    tick();
    chk("rd_hold_ack", ack, 2'b01);
    chk("rd_hold_oe", oe_n, 1);
    chk("rd_hold_ce", ce_n, 2'b10);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    req = 2'b00;
    tick();
    chk("rd_turn_ce", ce_n, 2'b11);
    chk("rd_turn_ack", ack, 0);
    tick();

    // Write, client 1. The ack comes in cycle 8.
    wdata[DW +: DW] = 32'hA5A55A5A;
    d_i = 32'h11112222;
    req = 2'b10; we = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("wr_doe", d_oe, 1);
      chk("wr_oe_n", oe_n, 1);
      chk("wr_ce", ce_n, 2'b01);
      chk("wr_d_o", d_o, 32'hA5A55A5A);
      chk("wr_we_n", we_n, (c >= 2 && c <= 7) ? 1'b0 : 1'b1);
      chk("wr_ack", ack, (c == 8) ? 2'b10 : 2'b00);
    end
    chk("wr_rdata_held", rdata, 32'hDEADBEEF);
    req = 2'b00; we = 2'b00;
    tick();
    chk("wr_turn_doe", d_oe, 0);
    chk("wr_turn_ce", ce_n, 2'b11);
    tick();

    // Both clients keep requesting. The last winner was client 1, so the
    // grants go 0,1,0,1.
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      d_i = 32'hC0DE0000 + 32'(t);
      tick();
      chk("rr_setup_ce", ce_n, (t % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_setup_a", a_o, (t % 2 == 0) ? 26'h0000123 : 26'h3000456);
      for (int c = 2; c <= 9; c++) tick();
      tick();
      chk("rr_ack", ack, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rdata", rdata, 32'hC0DE0000 + 32'(t));
      tick();
      chk("rr_turn_ce", ce_n, 2'b11);
      tick();
      chk("rr_idle_ce", ce_n, 2'b11);
    end
    req = 2'b00;
    tick();

    // Client 0 is granted, so the pointer now points at 0. Reset lands in
    // the third ACCESS cycle. Afterwards client 0 must still win first.
    req = 2'b01;
    tick(); tick(); tick(); tick();
    chk("mid_oe_before", oe_n, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ce", ce_n, 2'b11);
    chk("mid_rst_oe", oe_n, 1);
    chk("mid_rst_we", we_n, 1);
    chk("mid_rst_doe", d_oe, 0);
    chk("mid_rst_ack", ack, 0);
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("mid_after_ce", ce_n, 2'b10);
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("mid_after_noack", ack, 0);
    end
    tick();
    chk("mid_after_ack", ack, 2'b01);
    req = 2'b00;
    tick(); tick();

`ifdef FSM_BUS_RDY_EN
    // rdy is low for 3 cycles past the base strobe. The ack comes in cycle 13.
    d_i = 32'h0BADF00D;
    req = 2'b01; rdy = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 12) rdy = 1'b1;
      chk("rdy_noack", ack, 0);
      if (c >= 2) chk("rdy_oe", oe_n, 0);
    end
    tick();
    chk("rdy_ack", ack, 2'b01);
    chk("rdy_err", err, 0);
    chk("rdy_rdata", rdata, 32'h0BADF00D);
    req = 2'b00;
    tick(); tick();

    // rdy stays low. After 4 extra cycles the block times out, and the ack
    // and err pulse come in cycle 14.
    d_i = 32'h55555555;
    req = 2'b01; rdy = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      chk("tmo_noack", ack, 0);
    end
    tick();
    chk("tmo_ack", ack, 2'b01);
    chk("tmo_err", err, 2'b01);
    chk("tmo_rdata", rdata, 32'h0BADF00D);
    req = 2'b00; rdy = 1'b1;
    tick();
    chk("tmo_err_clr", err, 0);
`else
    // Without the ready feature, rdy is ignored and err stays 0.
    d_i = 32'h0BADF00D;
    req = 2'b01; rdy = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    tick();
    chk("nordy_ack", ack, 2'b01);
    chk("nordy_err", err, 0);
    chk("nordy_rdata", rdata, 32'h0BADF00D);
    req = 2'b00; rdy = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
